// File: rtl/mips_cycle_sequencer_if.sv
// Shared memory port handshake between the multicycle sequencer and the memory.
// The sequencer holds a request until the memory acknowledges it.
interface mips_cycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/mips_cycle_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a
// single shared memory port, with a retired-instruction counter.
module mips_cycle_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   register_write_enable,
  input  logic                   register_write_data_source,
  input  logic                   data_mem_write_enable,
  input  logic                   is_branch,
  input  logic                   alu_zero,
  mips_cycle_sequencer_if.master mem,
  output logic                   ir_load,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   alu_result_load,
  output logic                   mdr_load,
  output logic                   reg_write_strobe,
  output logic                   retire,
  output logic [2:0]             state,
  output logic [31:0]            instr_count
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;

  assign instr_count_d = instr_count_q + {31'd0, retire};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:     state_d = (run && mem.mem_ack) ? DECODE : FETCH;
      DECODE:    state_d = EXECUTE;
      EXECUTE: begin
        if (is_branch)                                               state_d = FETCH;
        else if (data_mem_write_enable || register_write_data_source) state_d = MEMORY;
        else if (register_write_enable)                              state_d = WRITEBACK;
        else                                                         state_d = FETCH;
      end
      MEMORY: begin
        if (!mem.mem_ack)               state_d = MEMORY;
        else if (data_mem_write_enable) state_d = FETCH;
        else                            state_d = WRITEBACK;
      end
      WRITEBACK: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_load          = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    alu_result_load  = 1'b0;
    mdr_load         = 1'b0;
    reg_write_strobe = 1'b0;
    retire           = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem.mem_req = run;
          if (run && mem.mem_ack) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXECUTE: begin
          alu_result_load = 1'b1;
          if (is_branch) begin
            pc_write = alu_zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end else if (!data_mem_write_enable && !register_write_data_source &&
                       !register_write_enable) begin
            retire = 1'b1;
          end
        end
        MEMORY: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = data_mem_write_enable;
          if (mem.mem_ack) begin
            // A store wins over a load when both controls are set.
            if (data_mem_write_enable) retire   = 1'b1;
            else                       mdr_load = 1'b1;
          end
        end
        WRITEBACK: begin
          reg_write_strobe = 1'b1;
          retire           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Self-checking bench for mips_cycle_sequencer: directed scenarios plus randomized
// instructions compared against a per-instruction reference model.
module tb_mips_cycle_sequencer;

  typedef enum int {K_BRANCH, K_NOP, K_STORE, K_LOAD, K_ALU} kind_e;
  typedef struct packed {
    logic [2:0] st;
    logic req, we, sel, ir, pcw, pcs, alu, mdr, rws, ret;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, run, rwe, rwds, dmwe, is_branch, alu_zero;
  logic        ir_load, pc_write, pc_src, alu_result_load, mdr_load, reg_write_strobe, retire;
  logic [2:0]  state;
  logic [31:0] instr_count;

  mips_cycle_sequencer_if mif ();

  mips_cycle_sequencer dut (
    .clk                        (clk),
    .reset                      (reset),
    .run                        (run),
    .register_write_enable      (rwe),
    .register_write_data_source (rwds),
    .data_mem_write_enable      (dmwe),
    .is_branch                  (is_branch),
    .alu_zero                   (alu_zero),
    .mem                        (mif),
    .ir_load                    (ir_load),
    .pc_write                   (pc_write),
    .pc_src                     (pc_src),
    .alu_result_load            (alu_result_load),
    .mdr_load                   (mdr_load),
    .reg_write_strobe           (reg_write_strobe),
    .retire                     (retire),
    .state                      (state),
    .instr_count                (instr_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_count = '0;
  int          fetch_left, mem_left;
  obs_t        trace[$];

  function automatic logic [9:0] strobes();
    return {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_load, pc_write, pc_src,
            alu_result_load, mdr_load, reg_write_strobe, retire};
  endfunction

  function automatic kind_e classify(input logic w, input logic ld, input logic st, input logic br);
    if (br) return K_BRANCH;
    if (st) return K_STORE;
    if (ld) return K_LOAD;
    if (w)  return K_ALU;
    return K_NOP;
  endfunction

  // One clock cycle starting at a falling edge; the memory acks after its wait count.
  task automatic run_cycle();
    obs_t o;
    mif.mem_ack = 1'b0;
    #1;
    if (mif.mem_req === 1'b1)
      mif.mem_ack = mif.mem_addr_sel ? (mem_left == 0) : (fetch_left == 0);
    #1;
    o = {state, strobes()};
    trace.push_back(o);
    if (mif.mem_req === 1'b1 && !mif.mem_ack) begin
      if (mif.mem_addr_sel) mem_left--;
      else                  fetch_left--;
    end
    @(negedge clk);
  endtask

  task automatic exec_instr(input logic i_rwe, input logic i_rwds, input logic i_dmwe,
                            input logic i_br, input logic i_z, input int fw, input int mw,
                            input string tag);
    kind_e       k;
    int          exp_st[$];
    int          n;
    bit          st_ok, bus_ok;
    int          c_ir, c_pcw, c_alu, c_mdr, c_rws, c_ret;
    logic [23:0] cnt, exp_cnt;
    string       s;
    rwe = i_rwe; rwds = i_rwds; dmwe = i_dmwe; is_branch = i_br; alu_zero = i_z;
    run = 1'b1; fetch_left = fw; mem_left = mw;
    k = classify(i_rwe, i_rwds, i_dmwe, i_br);
    repeat (fw + 1) exp_st.push_back(0);
    exp_st.push_back(1);
    exp_st.push_back(2);
    if (k == K_STORE || k == K_LOAD) repeat (mw + 1) exp_st.push_back(3);
    if (k == K_LOAD || k == K_ALU) exp_st.push_back(4);
    exp_count = exp_count + 32'd1;

    trace.delete();
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (trace[trace.size()-1].ret !== 1'b1 && n < 40);

    n_checks++;
    if (trace.size() != exp_st.size())
      $display("FAIL %s length: got %0d cycles, expected %0d", tag, trace.size(), exp_st.size());
    else n_pass++;

    st_ok = (trace.size() == exp_st.size());
    s = "";
    for (int i = 0; i < trace.size(); i++) begin
      s = {s, $sformatf("%0d", trace[i].st)};
      if (i < exp_st.size() && trace[i].st !== 3'(exp_st[i])) st_ok = 1'b0;
    end
    n_checks++;
    if (!st_ok) $display("FAIL %s state_trace: got %s, expected length %0d from model", tag, s, exp_st.size());
    else n_pass++;

    c_ir = 0; c_pcw = 0; c_alu = 0; c_mdr = 0; c_rws = 0; c_ret = 0;
    bus_ok = 1'b1;
    for (int i = 0; i < trace.size(); i++) begin
      c_ir  += int'(trace[i].ir  === 1'b1);
      c_pcw += int'(trace[i].pcw === 1'b1);
      c_alu += int'(trace[i].alu === 1'b1);
      c_mdr += int'(trace[i].mdr === 1'b1);
      c_rws += int'(trace[i].rws === 1'b1);
      c_ret += int'(trace[i].ret === 1'b1);
      if (trace[i].st == 3'd0 && {trace[i].req, trace[i].sel, trace[i].we} !== 3'b100) bus_ok = 1'b0;
      if (trace[i].st == 3'd3 &&
          {trace[i].req, trace[i].sel, trace[i].we} !== {2'b11, k == K_STORE}) bus_ok = 1'b0;
      if (trace[i].st == 3'd2 && k == K_BRANCH && {trace[i].pcw, trace[i].pcs} !== {i_z, 1'b1})
        bus_ok = 1'b0;
      if (trace[i].mdr === 1'b1 && !(i + 1 < trace.size() && trace[i+1].st == 3'd4)) bus_ok = 1'b0;
      if (trace[i].rws === 1'b1 && !(trace[i].st == 3'd4 && trace[i].ret === 1'b1)) bus_ok = 1'b0;
    end
    cnt     = {4'(c_ir), 4'(c_pcw), 4'(c_alu), 4'(c_mdr), 4'(c_rws), 4'(c_ret)};
    exp_cnt = {4'd1, 4'(1 + int'(k == K_BRANCH && i_z)), 4'd1, 4'(int'(k == K_LOAD)),
               4'(int'(k == K_LOAD || k == K_ALU)), 4'd1};
    n_checks++;
    if (cnt !== exp_cnt)
      $display("FAIL %s strobe_counts: got ir/pcw/alu/mdr/rws/ret=%h, expected %h", tag, cnt, exp_cnt);
    else n_pass++;

    n_checks++;
    if (!bus_ok) $display("FAIL %s bus_and_pulse_placement: got states %s, expected bus/pulse rules to hold", tag, s);
    else n_pass++;

    n_checks++;
    if (instr_count !== exp_count)
      $display("FAIL %s instr_count: got %h, expected %h", tag, instr_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; rwe = 1'b1; rwds = 1'b1; dmwe = 1'b1;
    is_branch = 1'b1; alu_zero = 1'b1; mif.mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (strobes() !== 10'b0) $display("FAIL reset_outputs: got %b, expected all zero", strobes());
    else n_pass++;
    n_checks++;
    if ({state, instr_count} !== 35'b0)
      $display("FAIL reset_state: got state=%0d count=%h, expected 0/0", state, instr_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_directed();
    exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "add");
    exec_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, "load_wait3");
    exec_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "load");
    exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, "beq_taken");
    exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "beq_not_taken");
    exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "store");
    exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, "store_over_load");
    exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, "nop");
    exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, "add_fetch_wait");
  endtask

  task automatic test_run_gating();
    bit         ok;
    logic       req_mid;
    logic [2:0] dropped;
    ok  = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mif.mem_ack = 1'b1;
      #1;
      if (mif.mem_req !== 1'b0 || ir_load !== 1'b0 || pc_write !== 1'b0 || state !== 3'd0) ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL run_low_idle: got activity with run=0, expected no request and FETCH");
    else n_pass++;

    run = 1'b1; mif.mem_ack = 1'b0;
    #1;
    req_mid = mif.mem_req;
    @(negedge clk);
    run = 1'b0; mif.mem_ack = 1'b1;
    #1;
    dropped = {mif.mem_req, ir_load, pc_write};
    @(negedge clk);
    n_checks++;
    if ({req_mid, dropped, state} !== {1'b1, 3'b000, 3'd0})
      $display("FAIL run_drop: got req=%b dropped=%b state=%0d, expected 1/000/0", req_mid, dropped, state);
    else n_pass++;
  endtask

  task automatic test_wrap();
    run = 1'b0; mif.mem_ack = 1'b0;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instr_count_q;
    @(negedge clk);
    exp_count = 32'hFFFF_FFFF;
    n_checks++;
    if (instr_count !== exp_count)
      $display("FAIL preload_hold: got %h, expected %h", instr_count, exp_count);
    else n_pass++;
    exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "wrap_nop");
    exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "after_wrap");
  endtask

  task automatic test_reset_abort();
    int  n;
    bit  ok;
    rwe = 1'b1; rwds = 1'b1; dmwe = 1'b0; is_branch = 1'b0; alu_zero = 1'b0;
    run = 1'b1; fetch_left = 0; mem_left = 10;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (state !== 3'd3 && n < 10);
    n_checks++;
    if (state !== 3'd3) $display("FAIL abort_reach_memory: got state %0d, expected 3", state);
    else n_pass++;

    reset = 1'b1; mif.mem_ack = 1'b1;
    #1;
    n_checks++;
    if (strobes() !== 10'b0) $display("FAIL abort_outputs: got %b, expected all zero", strobes());
    else n_pass++;
    @(negedge clk);
    exp_count = '0;
    n_checks++;
    if ({state, instr_count} !== {3'd0, exp_count})
      $display("FAIL abort_state: got state=%0d count=%h, expected 0/0", state, instr_count);
    else n_pass++;

    reset = 1'b0; run = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mif.mem_ack = 1'b1;
      #1;
      if (mif.mem_req !== 1'b0 || state !== 3'd0 || retire !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL abort_idle: got activity after reset with run=0, expected none");
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] r;
    for (int i = 0; i < 40; i++) begin
      r = 5'($urandom);
      exec_instr(r[0], r[1], r[2], r[3], r[4], int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_run_gating();
    test_back_to_back_random: begin
      test_random();
    end
    test_wrap();
    test_reset_abort();
    exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "post_abort_add");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_cycle_sequencer.md
MIPS_CYCLE_SEQUENCER -- requirements
Module: mips_cycle_sequencer

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-004 run  input  1  permits issue of a new instruction fetch; sampled only in FETCH.
REQ-005 register_write_enable  input  1  decoded control: instruction writes register file.
REQ-006 register_write_data_source  input  1  decoded control: 1 = load (data from memory).
REQ-007 data_mem_write_enable  input  1  decoded control: 1 = store.
REQ-008 is_branch  input  1  decoded control: conditional branch.
REQ-009 alu_zero  input  1  ALU zero flag; valid in EXECUTE.
REQ-010 mem_ack  input  1  shared memory port completion; ignored when mem_req = 0.
REQ-011 mem_req  output  1  shared memory port request.
REQ-012 mem_we  output  1  memory write (store); only meaningful with mem_req = 1.
REQ-013 mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result register (data access).
REQ-014 ir_load  output  1  load instruction register (one-cycle pulse).
REQ-015 pc_write  output  1  update PC (one-cycle pulse).
REQ-016 pc_src  output  1  0 = PC+4, 1 = branch target; meaningful only with pc_write = 1.
REQ-017 alu_result_load  output  1  capture ALU result (one-cycle pulse).
REQ-018 mdr_load  output  1  capture memory read data (one-cycle pulse).
REQ-019 reg_write_strobe  output  1  register-file write enable (one-cycle pulse).
REQ-020 retire  output  1  instruction completed (one-cycle pulse).
REQ-021 state  output  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
REQ-022 instr_count  output  32  count of retired instructions.

Function
REQ-023 All outputs except state and instr_count are combinational from state and inputs; state and instr_count are registered.
REQ-024 Decoded control inputs are held stable by the datapath from DECODE through the end of the instruction.
REQ-025 FETCH: mem_req = run, mem_we = 0, mem_addr_sel = 0. On mem_ack = 1 with mem_req = 1: ir_load = 1, pc_write = 1, pc_src = 0, next state DECODE. Otherwise remain in FETCH.
REQ-026 mem_ack arriving in the same cycle mem_req rises completes the access (zero-wait memory allowed).
REQ-027 mem_req, mem_we and mem_addr_sel stay constant until mem_ack; run falling while in FETCH drops mem_req and no access completes.
REQ-028 DECODE: no strobes; always advances to EXECUTE after exactly one cycle.
REQ-029 EXECUTE: alu_result_load = 1. Next state by priority:
  - is_branch: pc_write = alu_zero, pc_src = 1, retire = 1 -> FETCH.
  - data_mem_write_enable or register_write_data_source -> MEMORY.
  - register_write_enable -> WRITEBACK.
  - otherwise (no-op/unrecognised) retire = 1 -> FETCH.
REQ-030 MEMORY: mem_req = 1, mem_addr_sel = 1, mem_we = data_mem_write_enable. On mem_ack: load -> mdr_load = 1, next WRITEBACK; store -> retire = 1, next FETCH. No ack -> remain.
REQ-031 If data_mem_write_enable and register_write_data_source are both 1, store takes priority (mem_we = 1, no writeback).
REQ-032 WRITEBACK: reg_write_strobe = 1, retire = 1 for one cycle -> FETCH.
REQ-033 Latency with zero-wait memory: branch/no-op 3 cycles, R-type/addi/andi 4, store 4, load 5.
REQ-034 instr_count increments by 1 on every retire; wraps 0xFFFFFFFF -> 0x00000000.
REQ-035 State encodings 5-7 are illegal; if entered, next state is FETCH with all strobes 0.

Reset
REQ-036 While reset = 1 all combinational outputs are forced to 0, including mem_req and retire.
REQ-037 After reset edge: state = FETCH (0), instr_count = 0.
REQ-038 Reset in any state aborts the instruction: no retire, no pc_write, no reg_write_strobe; a coincident mem_ack is ignored.

Verification
REQ-039 Reset, run = 1, mem_ack tied 1, add (register_write_enable = 1) -> states 0,1,2,4,0; reg_write_strobe and retire at cycle 4; instr_count = 1.
REQ-040 Load with mem_ack delayed 3 cycles in MEMORY -> mem_req held 3 cycles with mem_addr_sel = 1, mem_we = 0; mdr_load one pulse; reg_write_strobe next cycle; total 8 cycles.
REQ-041 beq with alu_zero = 1 -> pc_write = 1, pc_src = 1 in EXECUTE; with alu_zero = 0 -> pc_write = 0; both retire, no reg_write_strobe.
REQ-042 Store (data_mem_write_enable = 1) -> MEMORY with mem_we = 1; retire on ack; no reg_write_strobe; 4 cycles.
REQ-043 Preload path: run 2^32 retirements (or force count to 0xFFFFFFFF) -> next retire gives instr_count = 0.
REQ-044 Assert reset in MEMORY with mem_ack = 1 -> no mdr_load/retire; next state FETCH, instr_count = 0; run = 0 in FETCH -> mem_req = 0 indefinitely.
